test_sequencer: RTL and testbench
=================================

Name: test_sequencer

Overview:
Synthesizable, parametrised successor to the component-level test aggregation used for the MIPS datapath units. It launches NUM_TESTS self-checking test channels one at a time and bounds each with a timeout counter instead of a fixed global delay. It collects per-channel pass, fail and timeout results into vectors and raises a single summary flag. It sits above the per-component checkers (adder, regfile, pc, shifter, ...) in simulation and FPGA bring-up builds.

Parameters:
NUM_TESTS, 10, number of test channels (1..32)
TIMEOUT_W, 16, width of the per-channel timeout counter
TIMEOUT, 20000, max cycles allowed per channel after launch; must fit in TIMEOUT_W
STOP_ON_FAIL, 0, 1 = abort the run at the first fail or timeout; 0 = run all channels
IDX_W (localparam), clog2(NUM_TESTS) min 1, width of the channel index

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle run request; ignored unless the FSM is in IDLE
test_start  out  NUM_TESTS  one-hot, one-cycle launch pulse to channel idx
test_done  in  NUM_TESTS  channel completion strobe; only bit [idx] is sampled
test_passed  in  NUM_TESTS  channel verdict, valid when its done bit is high
busy  out  1  high from the first LAUNCH cycle through RECORD of the final channel
all_done  out  1  sticky high after a run completes; cleared by the next start
all_passed  out  1  valid with all_done; 1 iff every channel passed
result_vec  out  NUM_TESTS  bit i = channel i passed
timeout_vec  out  NUM_TESTS  bit i = channel i timed out
current_idx  out  IDX_W  channel currently running or last run

Behaviour:
- Reset (asynchronous, active-high): FSM goes to IDLE.
- All outputs are 0 during reset, including result_vec, timeout_vec, current_idx and the counter.
- Reset asserted mid-run aborts the run immediately; no partial results are kept.
- FSM states: IDLE, LAUNCH, WAIT, RECORD, FINISH.
- IDLE, start=1 -> LAUNCH. On the same edge: idx=0, result_vec=0, timeout_vec=0, all_done=0, all_passed=0.
- LAUNCH (1 cycle):
  - test_start[idx]=1 and busy=1.
  - Counter cleared to 0.
  - -> WAIT.
- WAIT:
  - Counter increments each cycle.
  - If test_done[idx]=1: latch test_passed[idx] into result_vec[idx], then -> RECORD.
  - Else, when counter == TIMEOUT-1: timeout_vec[idx]=1, result_vec[idx]=0, then -> RECORD.
  - If done and timeout occur in the same cycle, done wins and counts as a normal verdict.
- RECORD (1 cycle):
  - -> FINISH if idx == NUM_TESTS-1.
  - -> FINISH if STOP_ON_FAIL=1 and result_vec[idx]=0.
  - Otherwise idx increments, -> LAUNCH.
- FINISH (1 cycle):
  - all_done=1.
  - all_passed = &result_vec over all NUM_TESTS bits; skipped channels count as failed.
  - busy=0, then -> IDLE.
- Results are held until the next accepted start.
- Inputs on non-selected channels (done or passed on bits other than idx) are ignored at all times.
- start asserted while not in IDLE is ignored; no queuing.
- A done strobe on channel idx during LAUNCH is ignored. Channels must respond at least 1 cycle after test_start.
- Minimum per-channel time is 3 cycles (LAUNCH, WAIT with done, RECORD).
- Worst-case per-channel time is TIMEOUT+2 cycles.
- The counter saturates and never wraps (the TIMEOUT terminal compare fires first).
- NUM_TESTS=1: idx stays 0 and the FSM goes straight to FINISH after RECORD.

Decomposition:
- Shared package holds:
  - FSM state encoding (3-bit localparams ST_IDLE..ST_FINISH)
  - default TIMEOUT and NUM_TESTS constants
  - clog2 function used for IDX_W
- One natural sub-module: timeout_counter.
  - Parameter: TIMEOUT_W.
  - Inputs: clear, enable, limit.
  - Output: expired.
  - Asynchronous active-high reset.
  - Reused later by the bus watchdog.
- Everything else (FSM, result registers) lives in test_sequencer.

Test Plan:
1. NUM_TESTS=4; each channel returns done+passed 5 cycles after its test_start -> after 4×(1+5+1)+1=29 cycles all_done=1, all_passed=1, result_vec=4'b1111, timeout_vec=0.
2. Channel 2 returns done with passed=0, STOP_ON_FAIL=0 -> run completes, result_vec=4'b1011, all_passed=0, channel 3 still launched.
3. Same as scenario 2 with STOP_ON_FAIL=1 -> test_start[3] never pulses, current_idx=2, result_vec=4'b0011, all_passed=0.
4. TIMEOUT=8; channel 1 never asserts done -> exactly 8 WAIT cycles, timeout_vec=4'b0010, result_vec[1]=0, channel 2 launched on the following LAUNCH.
5. Done asserted on the exact terminal cycle (counter=TIMEOUT-1) with passed=1 -> result_vec bit=1, timeout_vec bit=0.
6. Assert reset for 1 cycle mid-WAIT on channel 2 -> all outputs 0 asynchronously, FSM IDLE. A new start rerun from channel 0 produces the full passing result.

Source files
------------

// File: rtl/test_sequencer_pkg.sv
// test_sequencer_pkg: shared state encoding, default sizes and index-width helper for the test sequencer.
package test_sequencer_pkg;
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RECORD = 3'd3,
    ST_FINISH = 3'd4
  } state_t;
  localparam int DEFAULT_NUM_TESTS = 10;
  localparam int DEFAULT_TIMEOUT = 20000;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/timeout_counter.sv
// timeout_counter: clearable up-counter that stops at limit and flags expiry, never wrapping.
module timeout_counter #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expired
);
  logic [TIMEOUT_W-1:0] count;
  assign expired = count == limit;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clear) count <= '0;
    else if (enable && !expired && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/test_sequencer.sv
// test_sequencer: launches test channels one at a time, bounds each with a timeout and collects verdicts.
module test_sequencer
  import test_sequencer_pkg::*;
#(
  parameter int NUM_TESTS = DEFAULT_NUM_TESTS,
  parameter int TIMEOUT_W = 16,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int STOP_ON_FAIL = 0,
  localparam int IDX_W = (clog2(NUM_TESTS) < 1) ? 1 : clog2(NUM_TESTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic [NUM_TESTS-1:0] test_start,
  input  logic [NUM_TESTS-1:0] test_done,
  input  logic [NUM_TESTS-1:0] test_passed,
  output logic                 busy,
  output logic                 all_done,
  output logic                 all_passed,
  output logic [NUM_TESTS-1:0] result_vec,
  output logic [NUM_TESTS-1:0] timeout_vec,
  output logic [IDX_W-1:0]     current_idx
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_TESTS - 1);
  localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(TIMEOUT - 1);
  state_t state, next;
  logic expired, hit, ok;
  assign hit = test_done[current_idx];
  assign ok = result_vec[current_idx];
  timeout_counter #(.TIMEOUT_W(TIMEOUT_W)) u_timer (
    .clk(clk),
    .reset(reset),
    .clear(state == ST_LAUNCH),
    .enable(state == ST_WAIT),
    .limit(LIMIT),
    .expired(expired)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ST_IDLE;
    else state <= next;
  always_comb begin
    next = state;
    busy = state inside {ST_LAUNCH, ST_WAIT, ST_RECORD};
    test_start = (state == ST_LAUNCH) ? NUM_TESTS'(1) << current_idx : '0;
    case (state)
      ST_IDLE:   next = start ? ST_LAUNCH : ST_IDLE;
      ST_LAUNCH: next = ST_WAIT;
      ST_WAIT:   next = (hit || expired) ? ST_RECORD : ST_WAIT;
      ST_RECORD: next = (current_idx == LAST || (STOP_ON_FAIL != 0 && !ok)) ? ST_FINISH : ST_LAUNCH;
      ST_FINISH: next = ST_IDLE;
      default:   next = ST_IDLE;
    endcase
  end
  // Done takes priority over expiry when both land on the terminal WAIT cycle.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      current_idx <= '0;
      result_vec <= '0;
      timeout_vec <= '0;
      all_done <= 1'b0;
      all_passed <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:
          if (start) begin
            current_idx <= '0;
            result_vec <= '0;
            timeout_vec <= '0;
            all_done <= 1'b0;
            all_passed <= 1'b0;
          end
        ST_WAIT:
          if (hit) result_vec[current_idx] <= test_passed[current_idx];
          else if (expired) begin
            timeout_vec[current_idx] <= 1'b1;
            result_vec[current_idx] <= 1'b0;
          end
        ST_RECORD:
          if (next == ST_LAUNCH) current_idx <= current_idx + 1'b1;
        ST_FINISH: begin
          all_done <= 1'b1;
          all_passed <= &result_vec;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_test_sequencer.sv
// tb_test_sequencer: directed scenarios on a 4-channel sequencer (run-all and stop-on-fail builds, TIMEOUT=8).
module tb_test_sequencer;
  logic clk = 0, reset = 1, start = 0;
  logic [3:0] ts_a, done_a, passed_a, res_a, to_a;
  logic [3:0] ts_b, done_b, passed_b, res_b, to_b;
  logic busy_a, all_done_a, all_passed_a, busy_b, all_done_b, all_passed_b;
  logic [1:0] idx_a, idx_b;
  int dly[4] = '{5, 5, 5, 5};
  bit pass[4] = '{1, 1, 1, 1};
  bit noise = 0;
  int la[4], lb[4];
  int cyc = 0, cmp = 0, bad = 0;

  test_sequencer #(.NUM_TESTS(4), .TIMEOUT_W(16), .TIMEOUT(8), .STOP_ON_FAIL(0)) dut_a (
    .clk(clk), .reset(reset), .start(start), .test_start(ts_a), .test_done(done_a),
    .test_passed(passed_a), .busy(busy_a), .all_done(all_done_a), .all_passed(all_passed_a),
    .result_vec(res_a), .timeout_vec(to_a), .current_idx(idx_a));
  test_sequencer #(.NUM_TESTS(4), .TIMEOUT_W(16), .TIMEOUT(8), .STOP_ON_FAIL(1)) dut_b (
    .clk(clk), .reset(reset), .start(start), .test_start(ts_b), .test_done(done_b),
    .test_passed(passed_b), .busy(busy_b), .all_done(all_done_b), .all_passed(all_passed_b),
    .result_vec(res_b), .timeout_vec(to_b), .current_idx(idx_b));

  always #5 clk = ~clk;

  // Channel models: answer dly cycles after their launch pulse (dly=0 means never answer).
  initial begin : resp_a
    int cnt[4];
    int cur;
    cnt = '{default: 0};
    cur = 0;
    done_a = '0;
    passed_a = '0;
    forever begin
      @(posedge clk);
      #1;
      done_a = '0;
      passed_a = '0;
      for (int i = 0; i < 4; i++) begin
        if (reset) cnt[i] = 0;
        else if (ts_a[i]) begin cnt[i] = dly[i]; cur = i; end
        else if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin done_a[i] = 1'b1; passed_a[i] = pass[i]; end
        end
      end
      if (noise) done_a = done_a | ~(4'b0001 << cur);
    end
  end
  initial begin : resp_b
    int cnt[4];
    cnt = '{default: 0};
    done_b = '0;
    passed_b = '0;
    forever begin
      @(posedge clk);
      #1;
      done_b = '0;
      passed_b = '0;
      for (int i = 0; i < 4; i++) begin
        if (reset) cnt[i] = 0;
        else if (ts_b[i]) cnt[i] = dly[i];
        else if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin done_b[i] = 1'b1; passed_b[i] = pass[i]; end
        end
      end
    end
  end
  // Records the cycle of the first launch pulse per channel in the current run.
  initial begin : mon
    la = '{default: -1};
    lb = '{default: -1};
    forever begin
      @(negedge clk);
      cyc++;
      if (reset || (start && !busy_a)) la = '{default: -1};
      if (reset || (start && !busy_b)) lb = '{default: -1};
      for (int i = 0; i < 4; i++) begin
        if (ts_a[i] && la[i] < 0) la[i] = cyc;
        if (ts_b[i] && lb[i] < 0) lb[i] = cyc;
      end
    end
  end

  task automatic run(input int poke, output int na, output int nb);
    int n;
    n = 0;
    na = -1;
    nb = -1;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    while ((na < 0 || nb < 0) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      start = (n == poke);
      if (all_done_a && na < 0) na = n;
      if (all_done_b && nb < 0) nb = n;
    end
    start = 0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    cmp++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    cmp++; if (ts_a !== 4'b0) begin bad++; $display("FAIL reset_test_start: got %b want 0000", ts_a); end
    cmp++; if ({all_done_a, all_passed_a} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {all_done_a, all_passed_a}); end
    cmp++; if ({res_a, to_a, idx_a} !== 10'b0) begin bad++; $display("FAIL reset_vectors: got %h want 0", {res_a, to_a, idx_a}); end
    reset = 0;
  endtask

  task automatic test_all_pass;
    int na, nb;
    dly = '{5, 5, 5, 5};
    pass = '{1, 1, 1, 1};
    run(-1, na, nb);
    cmp++; if (na !== 29) begin bad++; $display("FAIL all_pass_cycles: got %0d want 29", na); end
    cmp++; if (all_passed_a !== 1'b1) begin bad++; $display("FAIL all_pass_flag: got %b want 1", all_passed_a); end
    cmp++; if (res_a !== 4'b1111) begin bad++; $display("FAIL all_pass_result: got %b want 1111", res_a); end
    cmp++; if (to_a !== 4'b0000) begin bad++; $display("FAIL all_pass_timeout: got %b want 0000", to_a); end
    cmp++; if ({busy_a, idx_a} !== 3'b011) begin bad++; $display("FAIL all_pass_idle_idx: got %b want 011", {busy_a, idx_a}); end
  endtask

  task automatic test_fail_continue;
    int na, nb;
    dly = '{5, 5, 5, 5};
    pass = '{1, 1, 0, 1};
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    cmp++; if (all_done_a !== 1'b0) begin bad++; $display("FAIL start_clears_done: got %b want 0", all_done_a); end
    repeat (40) @(posedge clk);
    #1;
    na = all_done_a;
    nb = la[3];
    cmp++; if (res_a !== 4'b1011) begin bad++; $display("FAIL cont_result: got %b want 1011", res_a); end
    cmp++; if ({na[0], all_passed_a} !== 2'b10) begin bad++; $display("FAIL cont_flags: got %b want 10", {na[0], all_passed_a}); end
    cmp++; if (nb < 0) begin bad++; $display("FAIL cont_ch3_launch: got %0d want launched", nb); end
  endtask

  task automatic test_stop_on_fail;
    int na, nb;
    dly = '{5, 5, 5, 5};
    pass = '{1, 1, 0, 1};
    run(-1, na, nb);
    cmp++; if (nb !== 22) begin bad++; $display("FAIL stop_cycles: got %0d want 22", nb); end
    cmp++; if (lb[3] !== -1) begin bad++; $display("FAIL stop_ch3_launch: got %0d want -1", lb[3]); end
    cmp++; if (idx_b !== 2'd2) begin bad++; $display("FAIL stop_idx: got %0d want 2", idx_b); end
    cmp++; if (res_b !== 4'b0011) begin bad++; $display("FAIL stop_result: got %b want 0011", res_b); end
    cmp++; if (all_passed_b !== 1'b0) begin bad++; $display("FAIL stop_passed: got %b want 0", all_passed_b); end
  endtask

  task automatic test_timeout;
    int na, nb;
    dly = '{5, 0, 5, 5};
    pass = '{1, 1, 1, 1};
    run(-1, na, nb);
    cmp++; if (la[2] - la[1] !== 10) begin bad++; $display("FAIL timeout_gap: got %0d want 10", la[2] - la[1]); end
    cmp++; if (to_a !== 4'b0010) begin bad++; $display("FAIL timeout_vec: got %b want 0010", to_a); end
    cmp++; if (res_a !== 4'b1101) begin bad++; $display("FAIL timeout_result: got %b want 1101", res_a); end
    cmp++; if (na !== 32) begin bad++; $display("FAIL timeout_cycles: got %0d want 32", na); end
    cmp++; if (lb[1] < 0 || lb[2] !== -1 || to_b !== 4'b0010) begin bad++; $display("FAIL timeout_stop: got launch2 %0d tov %b want -1 0010", lb[2], to_b); end
  endtask

  task automatic test_terminal_done;
    int na, nb;
    dly = '{5, 8, 5, 5};
    pass = '{1, 1, 1, 1};
    run(-1, na, nb);
    cmp++; if ({res_a, to_a} !== 8'b1111_0000) begin bad++; $display("FAIL terminal_done: got %b want 11110000", {res_a, to_a}); end
    cmp++; if ({na, all_passed_a} !== {32'd32, 1'b1}) begin bad++; $display("FAIL terminal_run: got %0d/%b want 32/1", na, all_passed_a); end
    dly = '{5, 9, 5, 5};
    run(-1, na, nb);
    cmp++; if ({res_a, to_a} !== 8'b1101_0010) begin bad++; $display("FAIL late_done: got %b want 11010010", {res_a, to_a}); end
  endtask

  task automatic test_reset_mid_run;
    int na, nb, n;
    dly = '{5, 5, 5, 5};
    pass = '{1, 1, 1, 1};
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    n = 0;
    while (la[2] < 0 && n < 100) begin @(posedge clk); n++; end
    cmp++; if (la[2] < 0) begin bad++; $display("FAIL mid_reach_ch2: got %0d want launched", la[2]); end
    repeat (2) @(posedge clk);
    #3 reset = 1;
    #1;
    cmp++; if ({busy_a, ts_a, res_a, to_a, idx_a, all_done_a} !== 16'b0) begin bad++; $display("FAIL mid_reset_outputs: got %h want 0", {busy_a, ts_a, res_a, to_a, idx_a, all_done_a}); end
    @(posedge clk); #1 reset = 0;
    run(-1, na, nb);
    cmp++; if ({na, res_a, all_passed_a} !== {32'd29, 4'b1111, 1'b1}) begin bad++; $display("FAIL mid_rerun: got %0d/%b/%b want 29/1111/1", na, res_a, all_passed_a); end
  endtask

  task automatic test_back_to_back;
    int na, nb;
    dly = '{5, 5, 5, 5};
    pass = '{1, 1, 1, 1};
    noise = 1;
    run(10, na, nb);
    noise = 0;
    cmp++; if (na !== 29) begin bad++; $display("FAIL b2b_cycles: got %0d want 29", na); end
    cmp++; if ({res_a, to_a, all_passed_a} !== 9'b1111_0000_1) begin bad++; $display("FAIL b2b_result: got %b want 111100001", {res_a, to_a, all_passed_a}); end
    repeat (3) @(posedge clk);
    #1;
    cmp++; if ({busy_a, all_done_a} !== 2'b01) begin bad++; $display("FAIL b2b_no_queue: got %b want 01", {busy_a, all_done_a}); end
  endtask

  initial begin
    test_reset;
    test_all_pass;
    test_fail_continue;
    test_stop_on_fail;
    test_timeout;
    test_terminal_done;
    test_reset_mid_run;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
